// File: rtl/serial_subtractor_if.sv
// Handshake and result bundle between an upstream controller and serial_subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first through one
// full-subtractor cell and a borrow flop; results update only at the end of an op.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0]    count;
    logic             br, br_n, d;
    logic             sa_sign, sb_sign;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q, overflow_q, zero_q, done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = SHIFT;
            SHIFT:   if (count == LAST) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs and the running borrow.
    always_comb begin
        d    = sa[0] ^ sb[0] ^ br;
        br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            br         <= 1'b0;
            count      <= '0;
            sa_sign    <= 1'b0;
            sb_sign    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa      <= bus.a;
                        sb      <= bus.b;
                        br      <= 1'b0;
                        count   <= '0;
                        sa_sign <= bus.a[WIDTH-1];
                        sb_sign <= bus.b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    res   <= {d, res[WIDTH-1:1]};
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    br    <= br_n;
                    count <= count + 1'b1;
                end
                FIN: begin
                    diff_q     <= res;
                    borrow_q   <= br;
                    overflow_q <= (sa_sign != sb_sign) && (res[WIDTH-1] != sa_sign);
                    zero_q     <= (res == '0);
                    done_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4; expected results hand-computed.
module tb_serial_subtractor;
    localparam int W   = 4;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] ed, input logic eb,
                             input logic eo, input logic ez);
        check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        check({tag, "_borrow"}, 32'(bus.borrow), 32'(eb));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
        check({tag, "_zero"}, 32'(bus.zero), 32'(ez));
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
        int n;
        launch(av, bv);
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check_res(tag, ed, eb, eo, ez);
        tick();
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int done_seen;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_res("rst", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // -7-3 and 3-(-7) both leave the signed 4-bit range.
        do_op("s9m3", 4'd9, 4'd3, 4'h6, 1'b0, 1'b1, 1'b0);
        do_op("s3m9", 4'd3, 4'd9, 4'hA, 1'b1, 1'b1, 1'b0);
        do_op("s5m5", 4'd5, 4'd5, 4'h0, 1'b0, 1'b0, 1'b1);
        do_op("s8m1", 4'd8, 4'd1, 4'h7, 1'b0, 1'b1, 1'b0);

        launch(4'd9, 4'd3);
        tick();
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
        tick();
        bus.start = 1'b0;
        check("ign_busy", 32'(bus.busy), 32'd1);
        check("ign_hold_diff", 32'(bus.diff), 32'h7);
        wait_done(n);
        check("ign_latency", 32'(n + 2), 32'(LAT));
        check_res("ign", 4'h6, 1'b0, 1'b1, 1'b0);
        tick();

        do_op("s0m0", 4'd0, 4'd0, 4'h0, 1'b0, 1'b0, 1'b1);
        do_op("s7m8", 4'd7, 4'd8, 4'hF, 1'b1, 1'b1, 1'b0);

        launch(4'd3, 4'd9);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check_res("mid_rst", 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check("mid_rst_no_done", 32'(done_seen), 32'd0);

        launch(4'd9, 4'd3);
        wait_done(n);
        check("b2b1_latency", 32'(n), 32'(LAT));
        check_res("b2b1", 4'h6, 1'b0, 1'b1, 1'b0);
        launch(4'd7, 4'd8);
        check("b2b_done_drop", 32'(bus.done), 32'd0);
        check("b2b_hold_diff", 32'(bus.diff), 32'h6);
        wait_done(n);
        check("b2b2_latency", 32'(n), 32'(LAT));
        check_res("b2b2", 4'hF, 1'b1, 1'b1, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
